iob_iob2wishbone: RTL and testbench

- IOb-bus slave to Wishbone B4 classic master bridge; the reverse direction of the team's Wishbone-to-IOb bridge.
- Lets IOb-native masters (CPU, DMA) reach Wishbone peripherals such as the 16550 core in native form.
- Single outstanding transaction; registered Wishbone outputs.
- Includes ack/err handling and a bus-timeout watchdog with a sticky error flag.

---
 rtl/iob_wb_pkg.sv | 14 +
 rtl/iob_wb_timeout.sv | 48 ++++
 rtl/iob_iob2wishbone.sv | 177 +++++++++++++++++
 tb/tb_iob_iob2wishbone.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_wb_pkg.sv
// rtl/iob_wb_pkg.sv - shared state encoding and defaults for the IOb/Wishbone bridges
package iob_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/iob_wb_timeout.sv
// rtl/iob_wb_timeout.sv - loadable up-counter with clear, enable and terminal count
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   cke_i         clock enable; register holds when low (reset still applies)
//   clr_i         clear to zero (highest priority after reset)
//   ld_i/ld_val_i load a value
//   en_i          increment by one
//   tc_o          high while the count equals TC_VAL
module iob_wb_timeout #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   TC_VAL = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cke_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cke_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/iob_iob2wishbone.sv
// rtl/iob_iob2wishbone.sv - IOb slave to Wishbone B4 classic master bridge
//
// Ports:
//   clk_i, rst_i, cke_i        clock, synchronous active-high reset, clock enable
//   iob_avalid_i/addr/wdata/wstrb  IOb request (wstrb all zero = read)
//   iob_rvalid_o/rdata_o       IOb read response (one-cycle pulse)
//   iob_ready_o                bridge idle and able to accept a request
//   wb_adr/dat/sel/we/cyc/stb_o registered Wishbone master outputs
//   wb_ack_i/err_i/dat_i       Wishbone slave response
//   err_o, err_clr_i           sticky bus-error/timeout flag and its clear
module iob_iob2wishbone
    import iob_wb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_ready_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic                err_o,
    input  logic                err_clr_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic WDOG_EN = (TIMEOUT_CYCLES != 0);
    // Counter is cleared on accept and reads 0 in the first BUS cycle, so the
    // abort fires at the end of BUS cycle number TIMEOUT_CYCLES.
    localparam logic [TIMEOUT_W-1:0] TC_VAL =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [STRB_W-1:0]   sel_q, sel_d;
    logic                we_q, we_d;
    logic                cyc_q, cyc_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_tc;
    logic                wdog_hit;
    logic                set_err;

    iob_wb_timeout #(
        .W      (TIMEOUT_W),
        .TC_VAL (TC_VAL)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cke_i    (cke_i),
        .clr_i    (cnt_clr),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .en_i     (cnt_en),
        .tc_o     (cnt_tc)
    );

    assign wdog_hit = WDOG_EN && cnt_tc;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rdata_d = rdata_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        set_err = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (iob_avalid_i) begin
                    adr_d   = iob_addr_i;
                    dat_d   = iob_wdata_i;
                    we_d    = |iob_wstrb_i;
                    sel_d   = (|iob_wstrb_i) ? iob_wstrb_i : '1;
                    cyc_d   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                cnt_en = 1'b1;
                // Error (or watchdog) wins over a simultaneous ack.
                if (wb_err_i || wdog_hit) begin
                    cyc_d   = 1'b0;
                    set_err = 1'b1;
                    if (we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end
                end else if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    if (we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdata_d = wb_dat_i;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase

        if (set_err) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign iob_ready_o  = (state_q == ST_IDLE);
    assign iob_rvalid_o = (state_q == ST_RESP);
    assign iob_rdata_o  = rdata_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_iob_iob2wishbone.sv
// tb/tb_iob_iob2wishbone.sv - scoreboard bench for the IOb to Wishbone bridge
module tb_iob_iob2wishbone;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 4;

    localparam int M_ACK = 0;
    localparam int M_ERR = 1;
    localparam int M_TMO = 2;

    logic          clk = 1'b0;
    logic          rst_i, cke_i;
    logic          iob_avalid_i;
    logic [AW-1:0] iob_addr_i;
    logic [DW-1:0] iob_wdata_i;
    logic [SW-1:0] iob_wstrb_i;
    logic          iob_rvalid_o;
    logic [DW-1:0] iob_rdata_o;
    logic          iob_ready_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o;
    logic          wb_ack_i, wb_err_i;
    logic [DW-1:0] wb_dat_i;
    logic          err_o, err_clr_i;

    always #5 clk = ~clk;

    iob_iob2wishbone #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_W      (3)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cke_i        (cke_i),
        .iob_avalid_i (iob_avalid_i),
        .iob_addr_i   (iob_addr_i),
        .iob_wdata_i  (iob_wdata_i),
        .iob_wstrb_i  (iob_wstrb_i),
        .iob_rvalid_o (iob_rvalid_o),
        .iob_rdata_o  (iob_rdata_o),
        .iob_ready_o  (iob_ready_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_we_o      (wb_we_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_dat_i     (wb_dat_i),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks     = 0;
    int   n_errors     = 0;
    int   rvalid_count = 0;
    logic exp_err      = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every rvalid pulse is matched against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (iob_rvalid_o === 1'b1) begin
            rvalid_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rvalid: got rdata 0x%08h expected no response", iob_rdata_o);
            end else begin
                e = exp_q.pop_front();
                chkv("rdata", iob_rdata_o, e.data);
                chk1("err_at_rvalid", err_o, e.err);
            end
        end
    end

    task automatic do_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] wstrb, input int waits, input int mode,
                          input logic [DW-1:0] rdat);
        logic          is_wr;
        logic [SW-1:0] exp_sel;
        exp_t          e;
        int            guard;
        is_wr   = |wstrb;
        exp_sel = is_wr ? wstrb : 4'hF;
        guard   = 0;
        while (iob_ready_o !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk1("ready_before_req", iob_ready_o, 1'b1);
        iob_avalid_i = 1'b1;
        iob_addr_i   = addr;
        iob_wdata_i  = wdata;
        iob_wstrb_i  = wstrb;
        @(negedge clk);
        iob_avalid_i = 1'b0;
        iob_wstrb_i  = '0;
        chk1("cyc_start", wb_cyc_o, 1'b1);
        chk1("stb_start", wb_stb_o, 1'b1);
        chk1("we", wb_we_o, is_wr);
        chkv("sel", 32'(wb_sel_o), 32'(exp_sel));
        chkv("adr", wb_adr_o, addr);
        if (is_wr) chkv("dat_o", wb_dat_o, wdata);
        chk1("ready_busy", iob_ready_o, 1'b0);
        if (!is_wr) begin
            e.data = (mode == M_ACK) ? rdat : '0;
            e.err  = (mode == M_ACK) ? exp_err : 1'b1;
            exp_q.push_back(e);
        end
        if (mode != M_ACK) exp_err = 1'b1;
        for (int i = 0; i < waits; i++) begin
            chk1("cyc_wait", wb_cyc_o, 1'b1);
            chkv("adr_stable", wb_adr_o, addr);
            chkv("sel_stable", 32'(wb_sel_o), 32'(exp_sel));
            @(negedge clk);
        end
        if (mode != M_TMO) begin
            wb_ack_i = (mode == M_ACK);
            wb_err_i = (mode == M_ERR);
            wb_dat_i = rdat;
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = 32'hBAD0BAD0;
        end
        chk1("cyc_drop", wb_cyc_o, 1'b0);
        chk1("stb_drop", wb_stb_o, 1'b0);
        if (!is_wr) begin
            chk1("rvalid_resp", iob_rvalid_o, 1'b1);
            chk1("ready_in_resp", iob_ready_o, 1'b0);
            @(negedge clk);
            chk1("rvalid_single", iob_rvalid_o, 1'b0);
        end else begin
            chk1("no_rvalid_write", iob_rvalid_o, 1'b0);
        end
        chk1("ready_after", iob_ready_o, 1'b1);
        chk1("err_after", err_o, exp_err);
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        exp_err   = 1'b0;
        chk1("err_cleared", err_o, 1'b0);
    endtask

    task automatic late_ack();
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk1("late_ack_cyc", wb_cyc_o, 1'b0);
        chk1("late_ack_ready", iob_ready_o, 1'b1);
        chk1("late_ack_err", err_o, exp_err);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        int cnt0;
        rst_i        = 1'b1;
        cke_i        = 1'b1;
        iob_avalid_i = 1'b0;
        iob_addr_i   = '0;
        iob_wdata_i  = '0;
        iob_wstrb_i  = '0;
        wb_ack_i     = 1'b0;
        wb_err_i     = 1'b0;
        wb_dat_i     = '0;
        err_clr_i    = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        // Reset state
        chk1("rst_ready", iob_ready_o, 1'b1);
        chk1("rst_cyc", wb_cyc_o, 1'b0);
        chk1("rst_stb", wb_stb_o, 1'b0);
        chk1("rst_we", wb_we_o, 1'b0);
        chkv("rst_sel", 32'(wb_sel_o), 32'h0);
        chkv("rst_adr", wb_adr_o, 32'h0);
        chkv("rst_dat", wb_dat_o, 32'h0);
        chk1("rst_rvalid", iob_rvalid_o, 1'b0);
        chkv("rst_rdata", iob_rdata_o, 32'h0);
        chk1("rst_err", err_o, 1'b0);

        // Read with two wait states, then zero-wait byte write
        do_txn(32'h10, 32'h0, 4'h0, 2, M_ACK, 32'hDEADBEEF);
        do_txn(32'h0C, 32'h000000A5, 4'h1, 0, M_ACK, 32'h0);
        chkv("rdata_hold", iob_rdata_o, 32'hDEADBEEF);

        // Bus error on a read in the second BUS cycle, then clear
        do_txn(32'h20, 32'h0, 4'h0, 1, M_ERR, 32'h12345678);
        chk1("err_sticky", err_o, 1'b1);
        clear_err();

        // Watchdog on a read and a write, each followed by a late ack
        do_txn(32'h30, 32'h0, 4'h0, TMO, M_TMO, 32'h0);
        late_ack();
        do_txn(32'h34, 32'h55AA55AA, 4'hF, TMO, M_TMO, 32'h0);
        late_ack();
        clear_err();

        // Reset in the middle of a read
        iob_avalid_i = 1'b1;
        iob_addr_i   = 32'h40;
        iob_wstrb_i  = 4'h0;
        @(negedge clk);
        iob_avalid_i = 1'b0;
        chk1("rstmid_cyc_up", wb_cyc_o, 1'b1);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk1("rstmid_cyc", wb_cyc_o, 1'b0);
        chk1("rstmid_ready", iob_ready_o, 1'b1);
        chk1("rstmid_rvalid", iob_rvalid_o, 1'b0);
        late_ack();

        // Clock-enable stall with ack held
        iob_avalid_i = 1'b1;
        iob_addr_i   = 32'h44;
        @(negedge clk);
        iob_avalid_i = 1'b0;
        exp_q.push_back('{data: 32'hCAFEF00D, err: 1'b0});
        cke_i    = 1'b0;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stall_cyc", wb_cyc_o, 1'b1);
            chk1("stall_rvalid", iob_rvalid_o, 1'b0);
        end
        cke_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk1("stall_cyc_drop", wb_cyc_o, 1'b0);
        chk1("stall_rvalid_up", iob_rvalid_o, 1'b1);
        @(negedge clk);
        chk1("stall_ready", iob_ready_o, 1'b1);

        // Back-to-back read, write, read
        cnt0 = rvalid_count;
        do_txn(32'h50, 32'h0, 4'h0, 0, M_ACK, 32'h11111111);
        do_txn(32'h54, 32'h22220000, 4'hC, 0, M_ACK, 32'h0);
        do_txn(32'h58, 32'h0, 4'h0, 0, M_ACK, 32'h33333333);
        chkv("b2b_rvalid_count", 32'(rvalid_count - cnt0), 32'd2);

        repeat (3) @(negedge clk);
        chkv("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
